// File: rtl/hci_core_mux_switch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hci_core_mux_switch_pkg : shared widths and FSM state type for the HCI mux  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package hci_core_mux_switch_pkg;

  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_BW = 8;
  localparam int unsigned DEFAULT_WW = 32;
  localparam int unsigned DEFAULT_UW = 1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } hci_mux_switch_state_t;

endpackage
`default_nettype wire

// File: rtl/hci_core_mux_switch_outstanding_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hci_outstanding_cnt : saturating count of granted-but-unanswered requests  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hci_outstanding_cnt #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          ASSERT_EN       = 1'b1,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] r_cnt;

  assign cnt   = r_cnt;
  assign full  = (r_cnt == c_MAX);
  assign empty = (r_cnt == '0);

  // A lone decrement at zero is a protocol error; the count stays pinned at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (inc && !dec && !full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (dec && !inc && !empty) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  if (ASSERT_EN) begin : g_underflow_chk
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec && !inc && empty && !clear));
  end

endmodule
`default_nettype wire

// File: rtl/hci_core_mux_switch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hci_core_mux_switch : N-to-1 HCI core mux that drains before reselecting   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hci_core_mux_switch
  import hci_core_mux_switch_pkg::*;
#(
  parameter int unsigned NB_CHAN         = 2,
  parameter int unsigned DW              = DEFAULT_DW,
  parameter int unsigned AW              = DEFAULT_AW,
  parameter int unsigned BW              = DEFAULT_BW,
  parameter int unsigned WW              = DEFAULT_WW,
  parameter int unsigned OW              = AW,
  parameter int unsigned UW              = DEFAULT_UW,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clear_i,
  input  logic [$clog2(NB_CHAN)-1:0]             sel_i,
  // slave channels
  input  logic [NB_CHAN-1:0]                     in_req,
  output logic [NB_CHAN-1:0]                     in_gnt,
  input  logic [NB_CHAN-1:0][AW-1:0]             in_add,
  input  logic [NB_CHAN-1:0]                     in_wen,
  input  logic [NB_CHAN-1:0][DW-1:0]             in_data,
  input  logic [NB_CHAN-1:0][DW/BW-1:0]          in_be,
  input  logic [NB_CHAN-1:0][DW/WW-1:0][OW-1:0]  in_boffs,
  input  logic [NB_CHAN-1:0][UW-1:0]             in_user,
  input  logic [NB_CHAN-1:0]                     in_lrdy,
  output logic [NB_CHAN-1:0]                     in_r_valid,
  output logic [NB_CHAN-1:0][DW-1:0]             in_r_data,
  output logic [NB_CHAN-1:0]                     in_r_opc,
  output logic [NB_CHAN-1:0][UW-1:0]             in_r_user,
  // master port
  output logic                                   out_req,
  input  logic                                   out_gnt,
  output logic [AW-1:0]                          out_add,
  output logic                                   out_wen,
  output logic [DW-1:0]                          out_data,
  output logic [DW/BW-1:0]                       out_be,
  output logic [DW/WW-1:0][OW-1:0]               out_boffs,
  output logic [UW-1:0]                          out_user,
  output logic                                   out_lrdy,
  input  logic                                   out_r_valid,
  input  logic [DW-1:0]                          out_r_data,
  input  logic                                   out_r_opc,
  input  logic [UW-1:0]                          out_r_user,
  // status
  output logic [$clog2(NB_CHAN)-1:0]             sel_o,
  output logic                                   busy_o,
  output logic                                   switching_o
);

  localparam int unsigned    SW        = $clog2(NB_CHAN);
  localparam int unsigned    CW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [SW:0]    c_NB_CHAN = (SW + 1)'(NB_CHAN);
  localparam logic [CW-1:0]  c_ONE     = CW'(1);

  hci_mux_switch_state_t r_state;
  logic [SW-1:0]         r_sel;
  logic [CW-1:0]         w_cnt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_sel_valid;
  logic                  w_switch_req;
  logic                  w_drained;
  logic                  w_fwd;
  logic                  w_hs;

  assign w_sel_valid  = ({1'b0, sel_i} < c_NB_CHAN);
  assign w_switch_req = w_sel_valid && (sel_i != r_sel);
  // No request is forwarded in a switch cycle, so the only possible change is a response.
  assign w_drained    = w_empty || ((w_cnt == c_ONE) && out_r_valid);
  assign w_fwd        = (r_state == RUN) && (sel_i == r_sel) && !w_full;
  assign w_hs         = out_req && out_gnt;

  assign out_req   = w_fwd && in_req[r_sel];
  assign out_add   = in_add[r_sel];
  assign out_wen   = in_wen[r_sel];
  assign out_data  = in_data[r_sel];
  assign out_be    = in_be[r_sel];
  assign out_boffs = in_boffs[r_sel];
  assign out_user  = in_user[r_sel];
  assign out_lrdy  = in_lrdy[r_sel];

  for (genvar ii = 0; ii < NB_CHAN; ii++) begin : g_chan
    localparam logic [SW-1:0] c_IDX = SW'(ii);
    assign in_gnt[ii]     = w_fwd && (r_sel == c_IDX) && out_gnt;
    assign in_r_valid[ii] = out_r_valid && (r_sel == c_IDX);
    assign in_r_data[ii]  = out_r_data;
    assign in_r_opc[ii]   = out_r_opc;
    assign in_r_user[ii]  = out_r_user;
  end

  hci_outstanding_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .ASSERT_EN       (1'b1),
    .CNT_W           (CW)
  ) u_outstanding_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (clear_i),
    .inc    (w_hs),
    .dec    (out_r_valid),
    .cnt    (w_cnt),
    .full   (w_full),
    .empty  (w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RUN;
      r_sel   <= '0;
    end else if (clear_i) begin
      r_state <= RUN;
      r_sel   <= w_sel_valid ? sel_i : '0;
    end else begin
      case (r_state)
        RUN: begin
          // A full window stalls everything, including a pending reselection.
          if (w_switch_req && !w_full) begin
            if (w_drained) r_sel   <= sel_i;
            else           r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_drained) begin
            r_state <= RUN;
            if (w_sel_valid) r_sel <= sel_i;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign sel_o       = r_sel;
  assign busy_o      = !w_empty;
  assign switching_o = (r_state == DRAIN) ||
                       ((r_state == RUN) && w_switch_req && !(w_drained && !w_full));

endmodule
`default_nettype wire

// File: tb/tb_hci_core_mux_switch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hci_core_mux_switch : randomized bench with a transaction-level model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hci_core_mux_switch;

  localparam int NB = 3, DW = 32, AW = 32, UW = 1, MAXO = 4;

  logic clk = 1'b0;
  logic rst_ni, clear_i;
  logic [1:0] sel_i;
  logic [NB-1:0] in_req, in_gnt, in_wen, in_lrdy, in_r_valid, in_r_opc;
  logic [NB-1:0][AW-1:0] in_add;
  logic [NB-1:0][DW-1:0] in_data, in_r_data;
  logic [NB-1:0][3:0] in_be;
  logic [NB-1:0][0:0][AW-1:0] in_boffs;
  logic [NB-1:0][UW-1:0] in_user, in_r_user;
  logic out_req, out_gnt, out_wen, out_lrdy, out_r_valid, out_r_opc;
  logic [AW-1:0] out_add;
  logic [DW-1:0] out_data, out_r_data;
  logic [3:0] out_be;
  logic [0:0][AW-1:0] out_boffs;
  logic [UW-1:0] out_user, out_r_user;
  logic [1:0] sel_o;
  logic busy_o, switching_o;

  logic cc_clear = 1'b0, cc_inc = 1'b0, cc_dec = 1'b0;
  logic [1:0] cc_cnt;
  logic cc_full, cc_empty;

  int n_vec = 0, n_err = 0;
  int m_sel = 0, m_cnt = 0;
  bit m_drain = 1'b0;
  int mq[$];
  int cyc = 0;
  bit withhold = 1'b0;
  int mem_lat = 1;

  always #5 clk = ~clk;

  hci_core_mux_switch #(
    .NB_CHAN(NB), .DW(DW), .AW(AW), .BW(8), .WW(32), .OW(AW), .UW(UW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .sel_i(sel_i),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen), .in_data(in_data),
    .in_be(in_be), .in_boffs(in_boffs), .in_user(in_user), .in_lrdy(in_lrdy),
    .in_r_valid(in_r_valid), .in_r_data(in_r_data), .in_r_opc(in_r_opc), .in_r_user(in_r_user),
    .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
    .out_data(out_data), .out_be(out_be), .out_boffs(out_boffs), .out_user(out_user),
    .out_lrdy(out_lrdy), .out_r_valid(out_r_valid), .out_r_data(out_r_data),
    .out_r_opc(out_r_opc), .out_r_user(out_r_user),
    .sel_o(sel_o), .busy_o(busy_o), .switching_o(switching_o)
  );

  hci_outstanding_cnt #(.MAX_OUTSTANDING(2), .ASSERT_EN(1'b0), .CNT_W(2)) u_cnt_alone (
    .clk_i(clk), .rst_ni(rst_ni), .clear(cc_clear), .inc(cc_inc), .dec(cc_dec),
    .cnt(cc_cnt), .full(cc_full), .empty(cc_empty)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit mem_rv();
    return !withhold && (mq.size() > 0) && (mq[0] <= cyc);
  endfunction

  // Each cycle starts at a negedge: the memory decides its response, then the caller drives requests.
  task automatic tick();
    @(negedge clk);
    out_r_valid = mem_rv();
    out_r_data  = $urandom;
    out_r_opc   = 1'($urandom);
    out_r_user  = 1'($urandom);
  endtask

  task automatic wait_idle();
    withhold = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick(); in_req = '0; #1;
      if (!busy_o) break;
    end
    check("drain_timeout", busy_o, 1'b0);
  endtask

  // Transaction-level reference: selection, outstanding count and drain flag.
  bit e_fwd, e_req, e_hs, e_sw, e_sv;
  int e_next;
  logic [NB-1:0] e_gnt, e_rv;

  always begin : cmp
    @(negedge clk); #2;
    if (!rst_ni) begin
      m_sel = 0; m_cnt = 0; m_drain = 1'b0; mq.delete();
    end else begin
      e_sv   = int'(sel_i) < NB;
      e_fwd  = !m_drain && (int'(sel_i) == m_sel) && (m_cnt < MAXO);
      e_req  = e_fwd && in_req[m_sel];
      e_hs   = e_req && out_gnt;
      e_next = m_cnt + int'(e_hs) - int'(out_r_valid);
      if (e_next < 0) e_next = 0;
      e_gnt = '0; if (e_fwd && out_gnt) e_gnt[m_sel] = 1'b1;
      e_rv  = '0; if (out_r_valid) e_rv[m_sel] = 1'b1;
      e_sw  = m_drain || (e_sv && int'(sel_i) != m_sel && !(m_cnt < MAXO && e_next == 0));

      check("out_req", out_req, e_req);
      check("in_gnt", in_gnt, e_gnt);
      check("in_r_valid", in_r_valid, e_rv);
      check("sel_o", sel_o, m_sel);
      check("busy_o", busy_o, m_cnt != 0);
      check("switching_o", switching_o, e_sw);
      if (e_req)
        check("req_fields", {out_add, out_wen, out_data, out_be, out_boffs, out_user, out_lrdy},
              {in_add[m_sel], in_wen[m_sel], in_data[m_sel], in_be[m_sel], in_boffs[m_sel],
               in_user[m_sel], in_lrdy[m_sel]});
      for (int i = 0; i < NB; i++)
        check("resp_bcast", {in_r_data[i], in_r_opc[i], in_r_user[i]},
              {out_r_data, out_r_opc, out_r_user});

      if (out_r_valid && mq.size() > 0) void'(mq.pop_front());
      if (out_req && out_gnt) mq.push_back(cyc + (mem_lat > 0 ? mem_lat : $urandom_range(1, 3)));

      if (clear_i) begin
        m_cnt = 0; m_drain = 1'b0; m_sel = e_sv ? int'(sel_i) : 0;
      end else begin
        if (!m_drain && e_sv && int'(sel_i) != m_sel && m_cnt < MAXO) begin
          if (e_next == 0) m_sel = int'(sel_i);
          else             m_drain = 1'b1;
        end else if (m_drain && e_next == 0) begin
          m_drain = 1'b0;
          if (e_sv) m_sel = int'(sel_i);
        end
        m_cnt = e_next;
      end
      cyc++;
    end
  end

  int n_gr, n_rv0;

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; sel_i = '0;
    in_req = '0; in_wen = '0; in_lrdy = '0; in_add = '0; in_data = '0; in_be = '0;
    in_boffs = '0; in_user = '0;
    out_gnt = 1'b0; out_r_valid = 1'b0; out_r_data = '0; out_r_opc = 1'b0; out_r_user = '0;
    #1;
    check("rst_status", {sel_o, busy_o, switching_o, out_req}, 5'b0);
    repeat (2) tick();
    rst_ni = 1'b1;

    // standalone counter: illegal decrement at zero, saturation, overlap, clear
    tick(); cc_dec = 1'b1;
    tick(); cc_dec = 1'b0; #1;
    check("cnt_underflow_hold", {cc_cnt, cc_empty}, 3'b001);
    tick(); cc_inc = 1'b1;
    tick();
    tick(); cc_inc = 1'b0; #1;
    check("cnt_full", {cc_cnt, cc_full}, 3'b101);
    tick(); cc_inc = 1'b1; cc_dec = 1'b1;
    tick(); cc_inc = 1'b0; cc_dec = 1'b0; #1;
    check("cnt_overlap", cc_cnt, 2'd2);
    tick(); cc_clear = 1'b1;
    tick(); cc_clear = 1'b0; #1;
    check("cnt_clear", cc_cnt, 2'd0);

    // single read on channel 0
    tick(); sel_i = 2'd0; in_req = 3'b001; in_add[0] = 32'h100; in_wen[0] = 1'b1; out_gnt = 1'b1; #1;
    check("t1_add", {out_req, out_add}, {1'b1, 32'h100});
    check("t1_gnt", in_gnt, 3'b001);
    tick(); in_req = '0; #1;
    check("t1_rvalid", {in_r_valid, busy_o}, 4'b0011);
    tick(); #1;
    check("t1_idle", busy_o, 1'b0);

    // window limit with responses withheld
    withhold = 1'b1; n_gr = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); in_req = 3'b001; in_add[0] = 32'h200 + 32'(i); #1;
      if (i >= 4) check("t2_blocked", out_req, 1'b0);
      if (out_req && out_gnt) n_gr++;
    end
    check("t2_granted", n_gr, 4);
    withhold = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (n_gr >= 6) break;
      tick(); in_req = 3'b001; #1;
      if (out_req && out_gnt) n_gr++;
    end
    check("t2_all_granted", n_gr, 6);
    wait_idle();

    // reselect with three reads outstanding
    withhold = 1'b1;
    repeat (3) begin tick(); in_req = 3'b001; end
    tick(); in_req = 3'b010; sel_i = 2'd1; in_add[1] = 32'h300; #1;
    check("t3_switching", {switching_o, out_req, in_gnt}, 5'b10000);
    repeat (2) tick();
    withhold = 1'b0; n_rv0 = 0;
    for (int k = 0; k < 20; k++) begin
      tick(); #1;
      if (sel_o == 2'd1) break;
      if (in_r_valid[0]) n_rv0++;
    end
    check("t3_rv_old", n_rv0, 3);
    check("t3_fwd_new", {sel_o, out_req, in_gnt}, 6'b01_1_010);
    wait_idle();

    // idle reselect costs exactly one cycle
    tick(); sel_i = 2'd0; in_req = 3'b001; #1;
    check("t4_penalty", {out_req, sel_o}, 3'b0_01);
    tick(); #1;
    check("t4_fwd", {out_req, sel_o}, 3'b1_00);
    wait_idle();

    // handshake and response every cycle keeps one outstanding
    tick(); in_req = 3'b001;
    for (int k = 0; k < 10; k++) begin
      tick(); #1;
      check("t5_overlap", {out_req, out_r_valid, busy_o}, 3'b111);
    end
    wait_idle();

    // asynchronous reset in the middle of a drain, then soft clear
    withhold = 1'b1;
    repeat (2) begin tick(); in_req = 3'b001; end
    tick(); in_req = '0; sel_i = 2'd1; #1;
    check("t6_block", switching_o, 1'b1);
    tick(); #1;
    check("t6_drain", {switching_o, busy_o, sel_o}, 4'b11_00);
    tick(); #1; rst_ni = 1'b0; withhold = 1'b0; #1;
    check("t6_async_rst", {sel_o, busy_o, switching_o}, 4'b0);
    tick(); rst_ni = 1'b1; sel_i = 2'd0;
    tick(); clear_i = 1'b1; sel_i = 2'd1; out_gnt = 1'b0;
    tick(); clear_i = 1'b0; #1;
    check("t6_clear_sel", {sel_o, busy_o}, 3'b01_0);
    tick(); clear_i = 1'b1; sel_i = 2'd3;
    tick(); clear_i = 1'b0; #1;
    check("t6_clear_bad_sel", sel_o, 2'd0);
    tick(); sel_i = 2'd0;

    // randomized traffic
    mem_lat = 0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if ($urandom_range(0, 15) == 0) sel_i = 2'($urandom_range(0, 3));
      in_req  = 3'($urandom) | 3'($urandom);
      in_wen  = 3'($urandom);
      in_lrdy = 3'($urandom);
      for (int i = 0; i < NB; i++) begin
        in_add[i] = $urandom; in_data[i] = $urandom; in_be[i] = 4'($urandom);
        in_boffs[i][0] = $urandom; in_user[i] = 1'($urandom);
      end
      out_gnt = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) withhold = !withhold;
      if (mq.size() == 0 && !out_r_valid && $urandom_range(0, 99) == 0) begin
        clear_i = 1'b1; out_gnt = 1'b0;
      end else begin
        clear_i = 1'b0;
      end
    end
    tick(); clear_i = 1'b0;
    wait_idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hci_core_mux_switch.md
Name: hci_core_mux_switch

Overview:
- Parametrised N-to-1 HCI core multiplexer, selected by sel_i, that is safe to reselect at any time.
- Tracks outstanding transactions on the current channel. On a selection change it blocks new requests, waits until all pending responses return, then switches.
- Sits between accelerator/DMA port groups and a single HCI core master port. Replaces the unchecked static mux wherever strict alternation cannot be guaranteed.

Parameters:
- NB_CHAN, 2, number of slave channels (>=2).
- DW, hci_package::DEFAULT_DW, data width.
- AW, hci_package::DEFAULT_AW, address width.
- BW, hci_package::DEFAULT_BW, byte width.
- WW, hci_package::DEFAULT_WW, word width for boffs.
- OW, AW, boffs element width.
- UW, hci_package::DEFAULT_UW, user width.
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions (>=1).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous soft clear.
- sel_i  input  $clog2(NB_CHAN)  requested channel.
- in  hci_core_intf.slave  [NB_CHAN-1:0]  slave channels.
- out  hci_core_intf.master  1  master port.
- sel_o  output  $clog2(NB_CHAN)  currently active channel (sel_q).
- busy_o  output  1  outstanding counter non-zero.
- switching_o  output  1  state is DRAIN.

Behaviour:
- One clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: sel_q=0, cnt=0, state=RUN; sel_o=0, busy_o=0, switching_o=0; out.req=0 unless in[0].req is asserted.
- Protocol: each handshake (out.req & out.gnt, read or write) yields exactly one out.r_valid, after a latency of 1 or more cycles.
- Counter cnt, width $clog2(MAX_OUTSTANDING+1), updated per cycle:
  - +1 on handshake, -1 on r_valid, unchanged when both occur.
  - r_valid with cnt==0 is a protocol violation: flag with an assertion, hold cnt at 0.
- RUN state:
  - Forwarded when sel_i==sel_q, sel_i<NB_CHAN and cnt<MAX_OUTSTANDING: out.req/add/wen/data/be/boffs/user/lrdy come from in[sel_q]; in[sel_q].gnt=out.gnt.
  - Request blocking: if cnt==MAX_OUTSTANDING, out.req=0 and in[sel_q].gnt=0 (stall, no transitions).
  - sel_i>=NB_CHAN is ignored: sel_q is held.
  - sel_i!=sel_q (valid): out.req=0 that cycle.
    - cnt==0, or cnt==1 with r_valid this cycle: sel_q<=sel_i, stay RUN. Switch penalty is 1 cycle.
    - Otherwise go to DRAIN.
- DRAIN state:
  - out.req=0. All in[*].gnt=0.
  - Responses still route to the old sel_q.
  - When cnt reaches 0 (including the r_valid cycle decrementing 1->0): sel_q<=sel_i, go to RUN.
  - sel_i returning to the old sel_q during DRAIN: still finish the drain, then RUN with the same sel_q.
  - sel_i changing again mid-drain: the value sampled at the exit edge wins.
- Responses:
  - in[ii].r_valid = out.r_valid only for ii==sel_q, else 0.
  - r_data/r_opc/r_user are broadcast to all channels.
  - gnt is 0 for every non-selected channel.
- Requests are combinational from in[sel_q] to out (no added latency). gnt is combinational.
- clear_i (synchronous, priority over all updates): cnt<=0, state<=RUN, sel_q<=sel_i if sel_i<NB_CHAN else 0.
  - Responses still in flight after clear_i are the user's responsibility. Allowed only when the interconnect is quiescent.
- Asynchronous reset mid-drain: immediate return to reset values.
- switching_o=1 in DRAIN and in a RUN cycle that blocks a pending switch. busy_o=(cnt!=0).

Decomposition:
- hci_package: add enum hci_mux_switch_state_t {RUN, DRAIN}.
- Sub-module hci_outstanding_cnt, parametrised by MAX_OUTSTANDING:
  - Inputs: inc, dec, clear.
  - Outputs: cnt, full, empty, underflow assertion.
  - Reusable by other HCI blocks.

Test Plan:
- Reset, sel_i=0, in[0] reads addr 0x100 with gnt=1 and r_valid one cycle later -> out.add=0x100 same cycle; in[0].r_valid=1; in[1].gnt=0 throughout; busy_o pulses 1 cycle.
- MAX_OUTSTANDING=4, memory withholds r_valid, in[0] issues 6 back-to-back reads -> 4 granted; out.req=0 from the 5th; cnt=4. Release responses -> remaining 2 granted.
- 3 reads outstanding, sel_i 0->1 -> switching_o=1; in[1].gnt=0 while 3 r_valids reach in[0] only; sel_o=1 on the edge after the last r_valid; in[1] request forwarded next cycle.
- cnt=0, sel_i 1->0 with in[0].req held -> exactly one cycle of out.req=0, then forwarding; sel_o=0.
- Simultaneous handshake and r_valid for 10 cycles at cnt=1 -> cnt stays 1. Illegal r_valid at cnt=0 -> assertion fires, cnt=0.
- rst_ni low mid-DRAIN (cnt=2, sel_i=1) -> sel_o=0, busy_o=0, switching_o=0 asynchronously. clear_i with sel_i=1 -> sel_o=1 next cycle, cnt=0.
